draw_seq: RTL and testbench
===========================

Name: draw_seq

Overview:
- Parametrised raster pattern generator. It is the next generation of the fixed 256x256 colour-cycling drawer.
- It scans every pixel of a frame and emits one write transaction per pixel (X, Y, R, G, B) towards the framebuffer writer. The writer applies back-pressure through a valid/ready handshake.
- It sequences through eight fill/gradient modes in two ways:
  - automatically, after a programmable number of frames;
  - under manual selection.
- It reports frame completion.

Parameters:
- XW, 8, X coordinate width; frame width = 2^XW.
- YW, 8, Y coordinate width; frame height = 2^YW.
- CW, 3, colour channel width. Constraint: CW <= XW and CW <= YW.
- FRAMES_PER_MODE, 256, completed frames per mode in auto mode. Must be >= 1.
- FCW, 9, width of the frame counter. Must satisfy 2^FCW > FRAMES_PER_MODE.

Ports:
- CLK, in, 1, system clock; all logic is on the rising edge.
- RST, in, 1, reset, synchronous, active-high.
- EN, in, 1, run enable.
- AUTO, in, 1, 1 = auto mode sequencing, 0 = manual selection.
- MODE_SEL, in, 3, manual mode number.
- READY, in, 1, framebuffer accepts the current pixel.
- WE, out, 1, pixel valid.
- X, out, XW, pixel column.
- Y, out, YW, pixel row.
- R, out, CW, red.
- G, out, CW, green.
- B, out, CW, blue.
- MODE, out, 3, active mode.
- FRAME_DONE, out, 1, one-cycle pulse after the last pixel of a frame is accepted.
- BUSY, out, 1, high while in DRAW or FEND.

Behaviour:
- Reset: state IDLE; WE = 0; X = 0; Y = 0; R, G and B = 0; MODE = 0; frame counter = 0; FRAME_DONE = 0. Reset asserted in any state, mid-frame included, takes effect on the next edge. No pending pixel survives reset.
- States: IDLE, DRAW, FEND.
- IDLE:
  - WE = 0.
  - When EN = 1: X and Y are 0, MODE is loaded (MODE_SEL if AUTO = 0, otherwise unchanged), go to DRAW.
  - WE rises on the edge that enters DRAW.
- DRAW:
  - WE = 1.
  - X, Y, R, G and B hold stable while READY = 0.
  - A pixel is accepted in a cycle with WE & READY.
  - On accept the raster advances: X increments; when X wraps to 0, Y increments.
  - Accepting pixel (2^XW-1, 2^YW-1) takes the state to FEND with WE = 0.
  - Throughput is 1 pixel/cycle when READY is held high.
- FEND (one cycle):
  - FRAME_DONE = 1 and WE = 0.
  - X and Y are back at 0.
  - In auto mode the frame counter increments. When it reaches FRAMES_PER_MODE, the counter clears and MODE increments, wrapping 7 -> 0 (no terminal mode).
  - In manual mode MODE loads MODE_SEL.
  - Next state: DRAW if EN = 1, else IDLE.
- AUTO and MODE_SEL are sampled only at IDLE->DRAW and in FEND. Changes mid-frame do not affect the current frame.
- EN deasserted mid-frame: the frame completes, then the block goes FEND -> IDLE.
- Colour is registered together with its coordinates. The R/G/B values are the function of the X, Y and MODE presented in the same cycle:
  - 0 white: R = G = B = all ones.
  - 1 cyan: R = 0, G = B = ones.
  - 2 red: R = ones, G = B = 0.
  - 3 magenta: R = B = ones, G = 0.
  - 4 green: G = ones, R = B = 0.
  - 5 yellow: R = G = ones, B = 0.
  - 6 gradient: R = 0, G = Y[YW-1 -: CW], B = X[XW-1 -: CW].
  - 7 gradient: R = X[XW-1 -: CW], G = Y[YW-1 -: CW], B = 0.
- READY while WE = 0 is ignored.
- The frame counter in manual mode stays at its current value; it clears when AUTO is sampled rising.

Decomposition:
- Package draw_pkg:
  - mode encodings MODE_WHITE..MODE_GRAD_RG (3-bit);
  - state encoding IDLE, DRAW, FEND.
- One combinational sub-module, draw_color, parametrised by XW, YW and CW:
  - inputs: mode, x, y;
  - outputs: r, g, b.
- The top instantiates draw_color on the next-pixel coordinates and registers its outputs.

Test Plan:
- XW = YW = 2, CW = 2, AUTO = 0, MODE_SEL = 2, EN = 1, READY = 1 -> 16 consecutive WE cycles covering (0,0)..(3,3) in raster order with R = 3, G = B = 0; FRAME_DONE pulses exactly once, one cycle after (3,3) is accepted.
- Same configuration, READY toggled 1,0,0,1 -> X, Y, R, G and B hold over the stall cycles; no pixel is skipped or duplicated; 16 accepts per frame.
- AUTO = 1, FRAMES_PER_MODE = 2, MODE starting at 6 -> 2 frames in mode 6, 2 in mode 7, then MODE = 0. Mode-7 pixel (2,1) gives R = 2, G = 1, B = 0.
- Mode 6 with XW = YW = 8, CW = 3 -> pixel X = 0xA0, Y = 0x40 gives R = 0, G = 2, B = 5.
- EN dropped at pixel 5 of a frame -> the frame completes to pixel 15, FRAME_DONE pulses, the block enters IDLE with WE = 0 and BUSY = 0.
- RST pulsed mid-frame at (1,2) -> the next cycle shows WE = 0, X = Y = 0, MODE = 0, colour outputs 0, state IDLE.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared encodings for the raster pattern generator.
//   state_e : controller states IDLE / DRAW / FEND
//   MODE_*  : 3-bit fill/gradient mode numbers
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FEND = 2'd2
  } state_e;

  localparam logic [2:0] MODE_WHITE   = 3'd0;
  localparam logic [2:0] MODE_CYAN    = 3'd1;
  localparam logic [2:0] MODE_RED     = 3'd2;
  localparam logic [2:0] MODE_MAGENTA = 3'd3;
  localparam logic [2:0] MODE_GREEN   = 3'd4;
  localparam logic [2:0] MODE_YELLOW  = 3'd5;
  localparam logic [2:0] MODE_GRAD_GB = 3'd6;
  localparam logic [2:0] MODE_GRAD_RG = 3'd7;

endpackage

// File: rtl/draw_seq_if.sv
// Pixel write channel from the pattern generator to the framebuffer writer.
//   we    : pixel valid (generator -> writer)
//   x, y  : pixel coordinates
//   r,g,b : pixel colour
//   ready : writer accepts the current pixel (writer -> generator)
interface draw_seq_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 8,
  parameter int unsigned CW = 3
) ();

  logic          we;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;
  logic          ready;

  modport master (output we, x, y, r, g, b, input ready);
  modport slave  (input we, x, y, r, g, b, output ready);

endinterface

// File: rtl/draw_color.sv
// Combinational colour function of mode and pixel coordinates.
//   mode  : active mode number
//   x, y  : pixel coordinates
//   r,g,b : colour; gradients take the top CW bits of the coordinates
module draw_color
  import draw_pkg::*;
#(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 8,
  parameter int unsigned CW = 3
) (
  input  logic [2:0]    mode,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  localparam logic [CW-1:0] ONES = {CW{1'b1}};

  logic [CW-1:0] x_top;
  logic [CW-1:0] y_top;

  assign x_top = x[XW-1 -: CW];
  assign y_top = y[YW-1 -: CW];

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    unique case (mode)
      MODE_WHITE:   begin r = ONES; g = ONES; b = ONES; end
      MODE_CYAN:    begin g = ONES; b = ONES; end
      MODE_RED:     begin r = ONES; end
      MODE_MAGENTA: begin r = ONES; b = ONES; end
      MODE_GREEN:   begin g = ONES; end
      MODE_YELLOW:  begin r = ONES; g = ONES; end
      MODE_GRAD_GB: begin g = y_top; b = x_top; end
      MODE_GRAD_RG: begin r = x_top; g = y_top; end
    endcase
  end

endmodule

// File: rtl/draw_seq.sv
// Raster pattern generator: scans a 2^XW x 2^YW frame, emitting one pixel write per
// pixel over a valid/ready channel, and steps through eight colour modes either
// automatically every FRAMES_PER_MODE frames or by manual selection.
//   clk, rst   : clock, synchronous active-high reset
//   en         : run enable
//   auto_mode  : 1 = auto mode sequencing, 0 = manual (mode_sel)
//   mode_sel   : manual mode number
//   pix        : pixel write channel (master side)
//   mode       : active mode
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
//   busy       : high in DRAW or FEND
module draw_seq
  import draw_pkg::*;
#(
  parameter int unsigned XW              = 8,
  parameter int unsigned YW              = 8,
  parameter int unsigned CW              = 3,
  parameter int unsigned FRAMES_PER_MODE = 256,
  parameter int unsigned FCW             = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       auto_mode,
  input  logic [2:0] mode_sel,
  draw_seq_if.master pix,
  output logic [2:0] mode,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [XW-1:0]  XMAX      = {XW{1'b1}};
  localparam logic [YW-1:0]  YMAX      = {YW{1'b1}};
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FRAMES_PER_MODE - 1);

  state_e        state_q;
  logic          we_q;
  logic [XW-1:0] x_q, x_nxt;
  logic [YW-1:0] y_q, y_nxt;
  logic [CW-1:0] r_q, g_q, b_q;
  logic [CW-1:0] r_nxt, g_nxt, b_nxt;
  logic [2:0]    mode_q, mode_nxt;
  logic [FCW-1:0] fcnt_q;
  logic          auto_q;  // auto_mode as last sampled, for rising detection
  logic          fd_q;
  logic          last_pix;

  assign last_pix = (x_q == XMAX) && (y_q == YMAX);

  // Coordinates and mode of the pixel to be presented next; the colour is derived
  // from these so it is registered alongside them.
  always_comb begin
    x_nxt    = x_q;
    y_nxt    = y_q;
    mode_nxt = mode_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          x_nxt    = '0;
          y_nxt    = '0;
          mode_nxt = auto_mode ? mode_q : mode_sel;
        end
      end
      DRAW: begin
        if (pix.ready) begin
          x_nxt = x_q + XW'(1);
          if (x_q == XMAX) y_nxt = y_q + YW'(1);
        end
      end
      FEND: begin
        x_nxt = '0;
        y_nxt = '0;
        if (!auto_mode) begin
          mode_nxt = mode_sel;
        end else if (auto_q && (fcnt_q == FCNT_LAST)) begin
          mode_nxt = mode_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  draw_color #(
    .XW(XW),
    .YW(YW),
    .CW(CW)
  ) u_color (
    .mode(mode_nxt),
    .x   (x_nxt),
    .y   (y_nxt),
    .r   (r_nxt),
    .g   (g_nxt),
    .b   (b_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      fcnt_q  <= '0;
      auto_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            mode_q  <= mode_nxt;
            r_q     <= r_nxt;
            g_q     <= g_nxt;
            b_q     <= b_nxt;
            auto_q  <= auto_mode;
            if (auto_mode && !auto_q) fcnt_q <= '0;
            we_q    <= 1'b1;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (pix.ready) begin
            x_q <= x_nxt;
            y_q <= y_nxt;
            r_q <= r_nxt;
            g_q <= g_nxt;
            b_q <= b_nxt;
            if (last_pix) begin
              we_q    <= 1'b0;
              fd_q    <= 1'b1;
              state_q <= FEND;
            end
          end
        end
        FEND: begin
          x_q    <= x_nxt;
          y_q    <= y_nxt;
          mode_q <= mode_nxt;
          r_q    <= r_nxt;
          g_q    <= g_nxt;
          b_q    <= b_nxt;
          auto_q <= auto_mode;
          // A frame finished in manual mode is not counted toward auto sequencing.
          if (auto_mode) begin
            if (!auto_q || (fcnt_q == FCNT_LAST)) fcnt_q <= '0;
            else                                   fcnt_q <= fcnt_q + FCW'(1);
          end
          if (en) begin
            we_q    <= 1'b1;
            state_q <= DRAW;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pix.we     = we_q;
  assign pix.x      = x_q;
  assign pix.y      = y_q;
  assign pix.r      = r_q;
  assign pix.g      = g_q;
  assign pix.b      = b_q;
  assign mode       = mode_q;
  assign frame_done = fd_q;
  assign busy       = (state_q == DRAW) || (state_q == FEND);

endmodule

// File: tb/tb_draw_seq.sv
// Directed bench for draw_seq on a 4x4 frame with 2-bit colour, plus a direct
// check of the colour function at 8-bit coordinates / 3-bit colour.
module tb_draw_seq;

  localparam int unsigned XW  = 2;
  localparam int unsigned YW  = 2;
  localparam int unsigned CW  = 2;
  localparam int unsigned FPM = 2;
  localparam int unsigned FCW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       auto_mode = 1'b0;
  logic [2:0] mode_sel = 3'd0;
  logic [2:0] mode;
  logic       frame_done;
  logic       busy;

  logic [2:0] c8_mode;
  logic [7:0] c8_x;
  logic [7:0] c8_y;
  logic [2:0] c8_r, c8_g, c8_b;

  int checks = 0;
  int failures = 0;

  draw_seq_if #(.XW(XW), .YW(YW), .CW(CW)) pix ();

  draw_seq #(
    .XW(XW),
    .YW(YW),
    .CW(CW),
    .FRAMES_PER_MODE(FPM),
    .FCW(FCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .auto_mode (auto_mode),
    .mode_sel  (mode_sel),
    .pix       (pix),
    .mode      (mode),
    .frame_done(frame_done),
    .busy      (busy)
  );

  draw_color #(.XW(8), .YW(8), .CW(3)) u_col8 (
    .mode(c8_mode),
    .x   (c8_x),
    .y   (c8_y),
    .r   (c8_r),
    .g   (c8_g),
    .b   (c8_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {r,g,b} for the 2-bit configuration.
  function automatic logic [5:0] col(input logic [2:0] m, input logic [1:0] x,
                                     input logic [1:0] y);
    case (m)
      3'd0:    col = {2'd3, 2'd3, 2'd3};
      3'd1:    col = {2'd0, 2'd3, 2'd3};
      3'd2:    col = {2'd3, 2'd0, 2'd0};
      3'd3:    col = {2'd3, 2'd0, 2'd3};
      3'd4:    col = {2'd0, 2'd3, 2'd0};
      3'd5:    col = {2'd3, 2'd3, 2'd0};
      3'd6:    col = {2'd0, y, x};
      default: col = {x, y, 2'd0};
    endcase
  endfunction

  task automatic check_pix(input string tag, input int p, input logic [2:0] m);
    logic [1:0] ex;
    logic [1:0] ey;
    ex = 2'(p % 4);
    ey = 2'(p / 4);
    chk({tag, "_we"}, pix.we, 1);
    chk({tag, "_x"}, pix.x, ex);
    chk({tag, "_y"}, pix.y, ey);
    chk({tag, "_mode"}, mode, m);
    chk({tag, "_rgb"}, {pix.r, pix.g, pix.b}, col(m, ex, ey));
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Full frame at READY=1; drops EN at pixel 5 when stop is set.
  task automatic run_frame(input string tag, input logic [2:0] m, input bit stop);
    for (int p = 0; p < 16; p++) begin
      check_pix(tag, p, m);
      if (m == 3'd7 && p == 6) begin
        chk({tag, "_px21_r"}, pix.r, 2);
        chk({tag, "_px21_g"}, pix.g, 1);
        chk({tag, "_px21_b"}, pix.b, 0);
      end
      if (stop && p == 5) en = 1'b0;
      step();
    end
    chk({tag, "_fend_fd"}, frame_done, 1);
    chk({tag, "_fend_we"}, pix.we, 0);
    chk({tag, "_fend_x"}, pix.x, 0);
    chk({tag, "_fend_y"}, pix.y, 0);
    chk({tag, "_fend_busy"}, busy, 1);
    step();
  endtask

  initial begin
    int p;
    int c;
    pix.ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_we", pix.we, 0);
    chk("rst_x", pix.x, 0);
    chk("rst_y", pix.y, 0);
    chk("rst_rgb", {pix.r, pix.g, pix.b}, 0);
    chk("rst_mode", mode, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_busy", busy, 0);

    // READY is ignored while idle
    rst = 1'b0;
    pix.ready = 1'b1;
    step();
    step();
    chk("idle_we", pix.we, 0);
    chk("idle_x", pix.x, 0);
    chk("idle_rgb", {pix.r, pix.g, pix.b}, 0);

    // Manual red frame at full throughput, EN dropped mid-frame
    mode_sel = 3'd2;
    en = 1'b1;
    step();
    run_frame("red", 3'd2, 1'b1);
    chk("red_idle_we", pix.we, 0);
    chk("red_idle_busy", busy, 0);
    chk("red_idle_fd", frame_done, 0);

    // Stalled frame: READY pattern 1,0,0,1
    en = 1'b1;
    step();
    p = 0;
    c = 0;
    while (p < 16 && c < 200) begin
      chk("stall_we", pix.we, 1);
      chk("stall_x", pix.x, p % 4);
      chk("stall_y", pix.y, p / 4);
      chk("stall_rgb", {pix.r, pix.g, pix.b}, 6'b11_00_00);
      chk("stall_fd", frame_done, 0);
      pix.ready = (c % 4 == 0) || (c % 4 == 3);
      if (p == 5) en = 1'b0;
      if (pix.ready) p++;
      c++;
      step();
    end
    chk("stall_accepts", p, 16);
    chk("stall_fend_fd", frame_done, 1);
    chk("stall_fend_we", pix.we, 0);
    pix.ready = 1'b1;
    step();
    chk("stall_idle_we", pix.we, 0);
    chk("stall_idle_busy", busy, 0);

    // Auto sequencing: start manually in mode 6, then switch to auto
    mode_sel = 3'd6;
    en = 1'b1;
    step();
    auto_mode = 1'b1;
    mode_sel = 3'd3;
    run_frame("man6", 3'd6, 1'b0);
    run_frame("auto6a", 3'd6, 1'b0);
    run_frame("auto6b", 3'd6, 1'b0);
    run_frame("auto7a", 3'd7, 1'b0);
    run_frame("auto7b", 3'd7, 1'b1);
    chk("auto_wrap_mode", mode, 0);
    chk("auto_idle_we", pix.we, 0);
    chk("auto_idle_busy", busy, 0);

    // Colour function at 8-bit coordinates, 3-bit colour
    c8_mode = 3'd6;
    c8_x = 8'hA0;
    c8_y = 8'h40;
    #1;
    chk("c8_m6_rgb", {c8_r, c8_g, c8_b}, {3'd0, 3'd2, 3'd5});
    c8_mode = 3'd7;
    #1;
    chk("c8_m7_rgb", {c8_r, c8_g, c8_b}, {3'd5, 3'd2, 3'd0});

    // Reset mid-frame at pixel (1,2)
    auto_mode = 1'b0;
    mode_sel = 3'd5;
    en = 1'b1;
    step();
    for (int i = 0; i < 9; i++) step();
    chk("mid_x", pix.x, 1);
    chk("mid_y", pix.y, 2);
    chk("mid_mode", mode, 5);
    rst = 1'b1;
    step();
    chk("mrst_we", pix.we, 0);
    chk("mrst_x", pix.x, 0);
    chk("mrst_y", pix.y, 0);
    chk("mrst_mode", mode, 0);
    chk("mrst_rgb", {pix.r, pix.g, pix.b}, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fd", frame_done, 0);
    rst = 1'b0;
    en = 1'b0;
    step();
    chk("post_rst_we", pix.we, 0);
    chk("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
